// File: rtl/data_memory_stage.sv
// MEM-stage data memory with a fixed multi-cycle access latency and upstream stall.
// Optional DMEM_LAST_HIT_EN: one-entry last-word tag lets a repeat read finish in one stall cycle.
module data_memory_stage #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] writedata_i,
  output logic [31:0] readdata_o,
  output logic        stall_o,
  output logic        misalign_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     data_q;
  logic            wr_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic            aligned;
  logic            start;
  logic            hit;
  logic            fast;
  logic            busy_done;
  logic            complete;
  logic            c_wr;
  logic [AW-1:0]   in_idx;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_data;
  logic            unused_addr;

  assign in_idx      = addr_i[AW+1:2];
  assign unused_addr = ^addr_i[31:AW+2];
  assign req         = memread_i | memwrite_i;
  assign aligned     = (addr_i[1:0] == 2'b00);
  assign start       = (state_q == StIdle) && req && aligned;

`ifdef DMEM_LAST_HIT_EN
  logic            tag_valid_q;
  logic [AW-1:0]   tag_idx_q;

  assign hit = !memwrite_i && tag_valid_q && (tag_idx_q == in_idx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_valid_q <= 1'b0;
      tag_idx_q   <= '0;
    end else if (complete) begin
      tag_valid_q <= 1'b1;
      tag_idx_q   <= c_idx;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Single-cycle accesses complete on the sampling edge, straight from the inputs.
  assign fast      = start && ((LATENCY == 32'd1) || hit);
  assign busy_done = (state_q == StBusy) && (cnt_q == '0);
  assign complete  = !rst_i && (fast || busy_done);

  always_comb begin
    c_wr   = wr_q;
    c_idx  = idx_q;
    c_data = data_q;
    if (fast) begin
      c_wr   = memwrite_i;
      c_idx  = in_idx;
      c_data = writedata_i;
    end
  end

  assign stall_o    = !rst_i && (start || (state_q == StBusy));
  assign misalign_o = !rst_i && (state_q == StIdle) && req && !aligned;

  always_ff @(posedge clk_i) begin
    if (complete && c_wr) begin
      mem[c_idx] <= c_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      readdata_o <= '0;
    end else begin
      if (complete && !c_wr) begin
        readdata_o <= mem[c_idx];
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            idx_q  <= in_idx;
            data_q <= writedata_i;
            wr_q   <= memwrite_i;
            if (fast) begin
              state_q <= StDone;
            end else begin
              state_q <= StBusy;
              cnt_q   <= CW'(LATENCY - 2);
            end
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_stage.sv
// Bench for data_memory_stage: directed scenarios plus random traffic against a
// transaction-timeline reference model checked every cycle.
module tb_data_memory_stage;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 3;
  localparam int unsigned AW    = $clog2(DEPTH);
`ifdef DMEM_LAST_HIT_EN
  localparam int HitSt = 1;
`else
  localparam int HitSt = LAT;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] readdata;
  logic        stall;
  logic        misalign;

  data_memory_stage #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .memread_i  (memread),
    .memwrite_i (memwrite),
    .addr_i     (addr),
    .writedata_i(wdata),
    .readdata_o (readdata),
    .stall_o    (stall),
    .misalign_o (misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each accepted access occupies cycles [t, t+lat) stalled, DONE at t+lat.
  int              cyc = 0;
  int              done_at = -1;
  bit              model_on = 0;
  bit              pend_wr;
  logic [AW-1:0]   pend_idx;
  logic [31:0]     pend_data;
  logic [31:0]     mem_m [DEPTH];
  bit              known [DEPTH];
  logic [31:0]     exp_rd = '0;
  bit              rd_valid = 0;
  bit              tag_v = 0;
  logic [AW-1:0]   tag_idx = '0;

  always @(negedge clk) begin : compare
    bit            es;
    bit            em;
    int            lat;
    logic [AW-1:0] idx;
    if (model_on && rd_valid) check("readdata", readdata, exp_rd);
    if (rst) begin
      if (model_on) begin
        check("stall_in_reset", stall, 0);
        check("misalign_in_reset", misalign, 0);
      end
      model_on = 1;
      done_at  = -1;
      exp_rd   = '0;
      rd_valid = 1;
      tag_v    = 0;
    end else if (model_on) begin
      es = 0;
      em = 0;
      if (cyc == done_at) begin
        es = 0;
      end else if (cyc < done_at) begin
        es = 1;
      end else if (memread || memwrite) begin
        if (addr[1:0] != 2'b00) begin
          em = 1;
        end else begin
          idx = addr[AW+1:2];
          lat = LAT;
`ifdef DMEM_LAST_HIT_EN
          if (!memwrite && tag_v && tag_idx == idx) lat = 1;
`endif
          es        = 1;
          done_at   = cyc + lat;
          pend_wr   = memwrite;
          pend_idx  = idx;
          pend_data = wdata;
        end
      end
      check("stall", stall, es);
      check("misalign", misalign, em);
      if (done_at == cyc + 1) begin
        if (pend_wr) begin
          mem_m[pend_idx] = pend_data;
          known[pend_idx] = 1;
        end else begin
          exp_rd   = mem_m[pend_idx];
          rd_valid = known[pend_idx];
        end
        tag_v   = 1;
        tag_idx = pend_idx;
      end
    end
    cyc++;
  end

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, output int stalls, output logic [31:0] rd_done,
                        output bit mis);
    memread  = rd;
    memwrite = wr;
    addr     = a;
    wdata    = d;
    stalls   = 0;
    mis      = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) mis = misalign;
      if (!stall) break;
      stalls++;
      if (k >= 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL access_timeout: stall high for %0d cycles, expected low by %0d", k + 1, LAT);
        break;
      end
      if (scramble) begin
        @(posedge clk);
        #1;
        addr  = $urandom;
        wdata = $urandom;
      end
    end
    rd_done = readdata;
    @(posedge clk);
    #1;
    memread  = 0;
    memwrite = 0;
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  initial begin : stim
    int            s;
    logic [31:0]   r;
    bit            m;
    int            op;
    logic [AW-1:0] idx;
    logic [31:0]   a;

    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("reset_readdata", readdata, 32'h0);
    check("reset_stall", stall, 0);

    access(0, 1, 32'h10, 32'hDEADBEEF, 0, s, r, m);
    check("wr_stalls", s, 3);
    check("wr_readdata_holds", r, 32'h0);
    access(1, 0, 32'h10, 32'h0, 0, s, r, m);
    check("rd_stalls", s, 3);
    check("rd_data", r, 32'hDEADBEEF);

    access(1, 0, 32'h13, 32'h0, 0, s, r, m);
    check("mis_rd_flag", m, 1);
    check("mis_rd_stalls", s, 0);
    check("mis_rd_readdata", r, 32'hDEADBEEF);
    access(0, 1, 32'h11, 32'h0, 0, s, r, m);
    check("mis_wr_flag", m, 1);
    access(1, 0, 32'h10, 32'h0, 0, s, r, m);
    check("mis_word4_kept", r, 32'hDEADBEEF);
    check("mis_reread_stalls", s, HitSt);

    access(0, 1, 32'h400, 32'h12345678, 0, s, r, m);
    access(1, 0, 32'h000, 32'h0, 0, s, r, m);
    check("wrap_data", r, 32'h12345678);
    check("wrap_stalls", s, HitSt);

    access(0, 1, 32'h20, 32'h0BADF00D, 0, s, r, m);
    memwrite = 1;
    addr     = 32'h20;
    wdata    = 32'hAAAA5555;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst      = 1;
    memwrite = 0;
    @(posedge clk);
    #1;
    rst = 0;
    check("abort_readdata", readdata, 32'h0);
    check("abort_stall", stall, 0);
    access(1, 0, 32'h20, 32'h0, 0, s, r, m);
    check("abort_old_data", r, 32'h0BADF00D);
    check("abort_rd_stalls", s, 3);

    access(0, 1, 32'h30, 32'hCAFEF00D, 1, s, r, m);
    access(1, 0, 32'h30, 32'h0, 0, s, r, m);
    check("hold_captured", r, 32'hCAFEF00D);
    access(1, 1, 32'h34, 32'h55AA55AA, 0, s, r, m);
    check("both_readdata_holds", r, 32'hCAFEF00D);
    check("both_stalls", s, 3);
    access(1, 0, 32'h34, 32'h0, 0, s, r, m);
    check("both_written", r, 32'h55AA55AA);

    access(0, 1, 32'h40, 32'h40404040, 0, s, r, m);
    access(0, 1, 32'h44, 32'h44444444, 0, s, r, m);
    access(1, 0, 32'h40, 32'h0, 0, s, r, m);
    check("tag_first_stalls", s, 3);
    check("tag_first_data", r, 32'h40404040);
    access(1, 0, 32'h40, 32'h0, 0, s, r, m);
    check("tag_repeat_stalls", s, HitSt);
    check("tag_repeat_data", r, 32'h40404040);
    access(1, 0, 32'h44, 32'h0, 0, s, r, m);
    check("tag_other_stalls", s, 3);
    check("tag_other_data", r, 32'h44444444);

    for (int i = 0; i < 16; i++) begin
      access(0, 1, 32'(i) << 2, $urandom, 0, s, r, m);
    end
    for (int i = 0; i < 300; i++) begin
      op  = $urandom_range(0, 9);
      idx = AW'($urandom_range(0, 15));
      a   = ($urandom & 32'hFFFF_FC00) | (32'(idx) << 2);
      if (op == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (op == 9) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end else begin
        access(op < 5, op >= 5, a, $urandom, 1'($urandom_range(0, 1)), s, r, m);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
